rot_cmd_stage: RTL and testbench

ROT_CMD_STAGE -- requirements
Module: rot_cmd_stage

---
 rtl/rot_pkg.sv | 13 +
 rtl/rot_cmd_fifo.sv | 57 +++++
 rtl/rot_cmd_stage.sv | 77 +++++++
 tb/tb_rot_cmd_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared widths, default depth and the queued command entry for the rotate command stage.
package rot_pkg;

  localparam int unsigned ROT_W         = 8;
  localparam int unsigned AMT_W         = 3;
  localparam int unsigned ROT_DEPTH_DEF = 2;

  typedef struct packed {
    logic [ROT_W-1:0] data;
    logic [AMT_W-1:0] amt;
  } rot_entry_t;

endpackage

// File: rtl/rot_cmd_fifo.sv
// In-order command FIFO; DEPTH must be a power of two so pointers wrap by overflow.
module rot_cmd_fifo
  import rot_pkg::*;
#(
  parameter int unsigned DEPTH = ROT_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rot_entry_t wr_entry,
  input  logic       pop,
  output rot_entry_t head,
  output logic       empty,
  output logic       full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  rot_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                do_push;
  logic                do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rot_cmd_stage.sv
// Rotate command stage: queues {byte, right-rotate amount}, feeds an external shifter, registers its result.
// Define ROT_CMD_LEFT_EN to honour in_dir (left rotates normalised to right rotates).
module rot_cmd_stage
  import rot_pkg::*;
#(
  parameter int unsigned DEPTH = ROT_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROT_W-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  output logic [ROT_W-1:0] sh_x,
  output logic [AMT_W-1:0] sh_amt,
  input  logic [ROT_W-1:0] sh_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROT_W-1:0] out_data
);

  rot_entry_t wr_entry;
  rot_entry_t head;
  logic       fifo_empty;
  logic       fifo_full;
  logic       push;
  logic       pop;

  // Left rotate by n equals right rotate by (8 - n) mod 8.
`ifdef ROT_CMD_LEFT_EN
  always_comb begin
    wr_entry.data = in_data;
    wr_entry.amt  = in_dir ? (AMT_W'(0) - in_amt) : in_amt;
  end
`else
  logic unused_dir;
  assign unused_dir = in_dir;
  always_comb begin
    wr_entry.data = in_data;
    wr_entry.amt  = in_amt;
  end
`endif

  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;
  assign pop      = !fifo_empty && (!out_valid || out_ready);
  assign sh_x     = head.data;
  assign sh_amt   = head.amt;

  rot_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wr_entry (wr_entry),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Output register: load on pop, drop valid once consumed; data holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= sh_y;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rot_cmd_stage.sv
// Directed/table-driven bench for rot_cmd_stage with a behavioural rotate-right shifter attached.
module tb_rot_cmd_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic       in_dir;
  logic [7:0] sh_x;
  logic [2:0] sh_amt;
  logic [7:0] sh_y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rotr(input logic [7:0] x, input logic [2:0] a);
    logic [15:0] t;
    t = {x, x} >> a;
    return t[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input logic [2:0] a);
    logic [15:0] t;
    t = {x, x} << a;
    return t[15:8];
  endfunction

  function automatic logic [7:0] ref_rot(input logic [7:0] x, input logic [2:0] a, input logic d);
`ifdef ROT_CMD_LEFT_EN
    return d ? rotl(x, a) : rotr(x, a);
`else
    return rotr(x, a);
`endif
  endfunction

  assign sh_y = rotr(sh_x, sh_amt);

  rot_cmd_stage #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .sh_x      (sh_x),
    .sh_amt    (sh_amt),
    .sh_y      (sh_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [2:0] amt;
    logic       dir;
    logic [2:0] e_amt;
    logic [7:0] e_out;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] exp_q[$];
  logic [7:0] bp_exp[3];

  initial begin
    int first_res, last_res, nres, nsent;
    logic [7:0] rd;
    logic [2:0] ra;
    logic       rdir;

    vecs[0] = '{8'h81, 3'd1, 1'b0, 3'd1, 8'hC0};
    vecs[1] = '{8'h01, 3'd1, 1'b0, 3'd1, 8'h80};
    vecs[2] = '{8'hA5, 3'd4, 1'b0, 3'd4, 8'h5A};
    vecs[3] = '{8'h12, 3'd0, 1'b0, 3'd0, 8'h12};
    vecs[4] = '{8'hF0, 3'd7, 1'b0, 3'd7, 8'hE1};
    vecs[5] = '{8'h81, 3'd0, 1'b1, 3'd0, 8'h81};
`ifdef ROT_CMD_LEFT_EN
    vecs[6] = '{8'h81, 3'd3, 1'b1, 3'd5, 8'h0C};
    vecs[7] = '{8'hC3, 3'd2, 1'b1, 3'd6, 8'h0F};
`else
    vecs[6] = '{8'h81, 3'd3, 1'b1, 3'd3, 8'h30};
    vecs[7] = '{8'hC3, 3'd2, 1'b1, 3'd2, 8'hF0};
`endif

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_dir = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'h00);
    chk("rst_sh_x",      32'(sh_x),      32'h00);
    chk("rst_sh_amt",    32'(sh_amt),    32'd0);
    @(negedge clk); rst = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Single commands through an idle pipeline.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = vecs[i].data; in_amt = vecs[i].amt; in_dir = vecs[i].dir;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("v%0d_sh_amt", i), 32'(sh_amt), 32'(vecs[i].e_amt));
      chk($sformatf("v%0d_sh_x", i),   32'(sh_x),   32'(vecs[i].data));
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vecs[i].e_out));
      @(posedge clk); #1;
      chk($sformatf("v%0d_cleared", i), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d_hold", i),    32'(out_data),  32'(vecs[i].e_out));
    end

    // Backpressure: 1 in output register + 2 in FIFO, 4th refused.
    bp_exp[0] = 8'h88; bp_exp[1] = 8'h11; bp_exp[2] = 8'h99;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(8'h11 * (k + 1)); in_amt = 3'd1; in_dir = 1'b0;
      chk($sformatf("bp_in_ready%0d", k), 32'(in_ready), (k < 3) ? 32'd1 : 32'd0);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_full_hold", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_valid%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_data%0d", k),  32'(out_data),  32'(bp_exp[k]));
      @(negedge clk);
    end
    chk("bp_drained_valid", 32'(out_valid), 32'd0);
    chk("bp_in_ready_back", 32'(in_ready),  32'd1);

    // Streaming with continuous valid/ready.
    nres = 0; nsent = 0; first_res = -1; last_res = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("st_unexpected", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk($sformatf("st_data%0d", nres), 32'(out_data), 32'(exp_q.pop_front()));
        end
        if (first_res < 0) first_res = c;
        last_res = c;
        nres++;
      end
      if (nsent < 16) begin
        rd = 8'($urandom); ra = 3'($urandom_range(0, 7)); rdir = 1'($urandom_range(0, 1));
        in_valid = 1'b1; in_data = rd; in_amt = ra; in_dir = rdir;
        chk($sformatf("st_in_ready%0d", nsent), 32'(in_ready), 32'd1);
        exp_q.push_back(ref_rot(rd, ra, rdir));
        nsent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("st_count", 32'(nres), 32'd16);
    chk("st_back_to_back", 32'(last_res - first_res), 32'd15);

    // Reset mid-stream with output held and 2 queued.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h5A + 8'(k); in_amt = 3'd2; in_dir = 1'b0;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("mr_pre_valid", 32'(out_valid), 32'd1);
    chk("mr_pre_full",  32'(in_ready),  32'd0);
    rst = 1'b1;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_out_data",  32'(out_data),  32'h00);
    chk("mr_sh_x",      32'(sh_x),      32'h00);
    @(negedge clk); rst = 1'b0;
    chk("mr_in_ready",  32'(in_ready),  32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("mr_no_stale%0d", c), 32'(out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
